// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shift op encoding and op legality helper for the NPC execute stage
//
// Purpose: the operation codes shared by issue logic and shift_unit.
//          Codes 3'b101..3'b111 are reserved and flagged illegal.
package npc_pkg;

  typedef enum logic [2:0] {
    SH_SLL = 3'b000,
    SH_SRL = 3'b001,
    SH_SRA = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100
  } sh_op_e;

  function automatic logic sh_op_legal(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational left shift / left rotate with fill bit
//
// Purpose: one slice of the shifter. STEP=8 uses only the shift-amount bits
//          above [2:0] (shift by multiples of 8); STEP=1 uses only bits [2:0].
// Ports:
//   data_i  operand
//   amt_i   full shift amount; bits outside this slice are ignored
//   rot_i   1: rotate left, 0: shift left
//   fill_i  value shifted in from the bottom when not rotating
//   data_o  result
module shift_core #(
  parameter  int WIDTH = 64,
  parameter  int STEP  = 1,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SH_W-1:0]  amt_i,
  input  logic             rot_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  localparam logic [SH_W-1:0] FINE_MASK = SH_W'(7);
  localparam logic [SH_W-1:0] AMT_MASK  = (STEP == 8) ? ~FINE_MASK : FINE_MASK;

  logic [SH_W-1:0]  sh;
  logic [SH_W:0]    back_sh;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] wrap;
  logic [WIDTH-1:0] fill_mask;

  always_comb begin
    sh        = amt_i & AMT_MASK;
    shl       = data_i << sh;
    // sh=0 gives back_sh=WIDTH, which shifts everything out: no wrap bits.
    back_sh   = (SH_W+1)'(WIDTH) - {1'b0, sh};
    wrap      = data_i >> back_sh;
    fill_mask = ~({WIDTH{1'b1}} << sh);
    data_o    = rot_i ? (shl | wrap) : (shl | (fill_i ? fill_mask : '0));
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - two-stage pipelined shifter with valid/ready handshakes
//
// Purpose: SLL/SRL/SRA/ROL/ROR with RV64 word variants. S1 decodes, normalises
//          word ops and applies the coarse (x8) shift. S2 is the output
//          register: it applies the fine shift and word sign-extension.
//          Right ops are done by bit-reversing around the left-shift cores.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      kill all in-flight operations on the next edge
//   in_valid/in_ready          request handshake
//   in_op, in_word, in_data,
//   in_shamt, in_tag           request payload
//   out_valid/out_ready        result handshake
//   out_data, out_tag,
//   out_illegal                result payload (illegal => out_data = 0)
module shift_unit
  import npc_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int TAG_W = 5,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [2:0]       s1_fine_q, s1_fine_d;
  logic             s1_rot_q, s1_rot_d;
  logic             s1_right_q, s1_right_d;
  logic             s1_fill_q, s1_fill_d;
  logic             s1_word_q, s1_word_d;
  logic             s1_ill_q, s1_ill_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_ill_q, out_ill_d;

  sh_op_e           op;
  logic             is_rot, is_sra, is_right, fill, word;
  logic [WIDTH-1:0] norm_data, pre_data, coarse_data, fine_data, res_data, ext_data;
  logic [SH_W-1:0]  norm_shamt, fine_amt;
  logic             out_fire, s2_free, s1_adv, in_fire;

  assign op = sh_op_e'(in_op);

  always_comb begin
    is_rot   = (op == SH_ROL) || (op == SH_ROR);
    is_sra   = (op == SH_SRA);
    is_right = (op == SH_SRL) || is_sra || (op == SH_ROR);
    pre_data = is_right ? bit_rev(norm_data) : norm_data;
    fill     = is_sra & norm_data[WIDTH-1];
  end

  generate
    if (WIDTH == 64) begin : g_word
      logic [31:0] lo;
      assign lo   = in_data[31:0];
      assign word = in_word;
      // Word rotates duplicate the low word so a 64-bit rotate yields the
      // 32-bit rotate in the low half; SRA pre-extends so the fill is bit 31.
      always_comb begin
        norm_data  = in_data;
        norm_shamt = in_shamt;
        if (in_word) begin
          norm_shamt = {1'b0, in_shamt[4:0]};
          if (is_rot)      norm_data = {lo, lo};
          else if (is_sra) norm_data = {{32{lo[31]}}, lo};
          else             norm_data = {32'd0, lo};
        end
      end
      assign ext_data = s1_word_q ? {{32{res_data[31]}}, res_data[31:0]} : res_data;
    end else begin : g_noword
      assign word       = 1'b0;
      assign norm_data  = in_data;
      assign norm_shamt = in_shamt;
      assign ext_data   = res_data;
    end
  endgenerate

  shift_core #(.WIDTH(WIDTH), .STEP(8)) u_coarse (
    .data_i (pre_data),
    .amt_i  (norm_shamt),
    .rot_i  (is_rot),
    .fill_i (fill),
    .data_o (coarse_data)
  );

  assign fine_amt = SH_W'(s1_fine_q);

  shift_core #(.WIDTH(WIDTH), .STEP(1)) u_fine (
    .data_i (s1_data_q),
    .amt_i  (fine_amt),
    .rot_i  (s1_rot_q),
    .fill_i (s1_fill_q),
    .data_o (fine_data)
  );

  assign res_data = s1_right_q ? bit_rev(fine_data) : fine_data;

  always_comb begin
    out_fire = out_valid_q && out_ready;
    s2_free  = !out_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !flush && (!s1_valid_q || s1_adv);
    in_fire  = in_valid && in_ready;

    s1_data_d  = s1_data_q;
    s1_fine_d  = s1_fine_q;
    s1_rot_d   = s1_rot_q;
    s1_right_d = s1_right_q;
    s1_fill_d  = s1_fill_q;
    s1_word_d  = s1_word_q;
    s1_ill_d   = s1_ill_q;
    s1_tag_d   = s1_tag_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    out_ill_d  = out_ill_q;

    if (in_fire) begin
      s1_data_d  = coarse_data;
      s1_fine_d  = norm_shamt[2:0];
      s1_rot_d   = is_rot;
      s1_right_d = is_right;
      s1_fill_d  = fill;
      s1_word_d  = word;
      s1_ill_d   = !sh_op_legal(in_op);
      s1_tag_d   = in_tag;
    end

    if (s1_adv && !flush) begin
      out_data_d = s1_ill_q ? '0 : ext_data;
      out_tag_d  = s1_tag_q;
      out_ill_d  = s1_ill_q;
    end

    if (flush)        s1_valid_d = 1'b0;
    else if (in_fire) s1_valid_d = 1'b1;
    else if (s1_adv)  s1_valid_d = 1'b0;
    else              s1_valid_d = s1_valid_q;

    // A handshake in the flush cycle has already completed; clearing valid is all flush does.
    if (flush)         out_valid_d = 1'b0;
    else if (s1_adv)   out_valid_d = 1'b1;
    else if (out_fire) out_valid_d = 1'b0;
    else               out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_fine_q   <= '0;
      s1_rot_q    <= 1'b0;
      s1_right_q  <= 1'b0;
      s1_fill_q   <= 1'b0;
      s1_word_q   <= 1'b0;
      s1_ill_q    <= 1'b0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_ill_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_fine_q   <= s1_fine_d;
      s1_rot_q    <= s1_rot_d;
      s1_right_q  <= s1_right_d;
      s1_fill_q   <= s1_fill_d;
      s1_word_q   <= s1_word_d;
      s1_ill_q    <= s1_ill_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_ill_q   <= out_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit (WIDTH=64)
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic        in_word;
  logic [63:0] in_data;
  logic [5:0]  in_shamt;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic        out_illegal;

  shift_unit #(.WIDTH(64), .TAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_word     (in_word),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        word;
    logic [63:0] data;
    logic [5:0]  shamt;
    logic [63:0] exp;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  t;
    logic        ill;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   pop_cyc[$];
  vec_t vecs[17];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] d, input logic [5:0] s);
    logic [31:0] x, r32;
    logic [63:0] r;
    int k;
    r32 = '0;
    r   = '0;
    if (op > 3'd4) return 64'd0;
    if (w) begin
      x = d[31:0];
      k = int'(s[4:0]);
      case (op)
        3'd0: r32 = x << k;
        3'd1: r32 = x >> k;
        3'd2: r32 = $signed(x) >>> k;
        3'd3: r32 = (x << k) | (x >> (32 - k));
        default: r32 = (x >> k) | (x << (32 - k));
      endcase
      return {{32{r32[31]}}, r32};
    end
    k = int'(s);
    case (op)
      3'd0: r = d << k;
      3'd1: r = d >> k;
      3'd2: r = $signed(d) >>> k;
      3'd3: r = (d << k) | (d >> (64 - k));
      default: r = (d >> k) | (d << (64 - k));
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got data %h tag %0d expected none", out_data, out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_tag", 64'(out_tag), 64'(e.t));
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic w, input logic [63:0] d,
                       input logic [5:0] s, input logic [4:0] t);
    in_op    = op;
    in_word  = w;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
    in_valid = 1'b1;
  endtask

  task automatic push(input logic [63:0] d, input logic [4:0] t, input logic ill);
    exp_t e;
    e.d   = d;
    e.t   = t;
    e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic w, input logic [63:0] d,
                      input logic [5:0] s, input logic [4:0] t,
                      input logic [63:0] exp, input logic ill);
    int n = 0;
    @(negedge clk);
    drive(op, w, d, s, t);
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready %b expected 1 (tag %0d)", in_ready, t);
    end else begin
      push(exp, t, ill);
    end
  endtask

  task automatic lat_check();
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || out_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    int acc;
    int idx;
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] rd;
    logic [5:0]  rs;

    vecs[0]  = '{3'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{3'd2, 1'b1, 64'h0000_0000_8000_0010, 6'd36, 64'hFFFF_FFFF_F800_0001, 1'b0};
    vecs[2]  = '{3'd4, 1'b1, 64'h0000_0000_0000_0001, 6'd1,  64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[3]  = '{3'd0, 1'b0, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000, 1'b0};
    vecs[4]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'h0000_0000_0000_0001, 1'b0};
    vecs[5]  = '{3'd3, 1'b0, 64'h8000_0000_0000_0001, 6'd4,  64'h0000_0000_0000_0018, 1'b0};
    vecs[6]  = '{3'd4, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd8,  64'hEF01_2345_6789_ABCD, 1'b0};
    vecs[7]  = '{3'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd0,  64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[8]  = '{3'd0, 1'b1, 64'h0000_0000_4000_0000, 6'd1,  64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[9]  = '{3'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd31, 64'h0000_0000_0000_0001, 1'b0};
    vecs[10] = '{3'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 6'd0,  64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
    vecs[11] = '{3'd5, 1'b0, 64'h0000_0000_0000_FFFF, 6'd3,  64'h0000_0000_0000_0000, 1'b1};
    vecs[12] = '{3'd2, 1'b0, 64'h7000_0000_0000_0000, 6'd60, 64'h0000_0000_0000_0007, 1'b0};
    vecs[13] = '{3'd3, 1'b1, 64'h0000_0000_8000_0001, 6'd1,  64'h0000_0000_0000_0003, 1'b0};
    vecs[14] = '{3'd2, 1'b0, 64'h8000_0000_0000_0000, 6'd9,  64'hFFC0_0000_0000_0000, 1'b0};
    vecs[15] = '{3'd0, 1'b0, 64'h0000_0000_0000_00FF, 6'd13, 64'h0000_0000_001F_E000, 1'b0};
    vecs[16] = '{3'd1, 1'b1, 64'h0000_0000_0000_0100, 6'd36, 64'h0000_0000_0000_0010, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(3'd0, 1'b0, 64'd0, 6'd0, 5'd0);
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_out_illegal", 64'(out_illegal), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 17; i++) begin
      send(vecs[i].op, vecs[i].word, vecs[i].data, vecs[i].shamt, 5'(i),
           vecs[i].exp, vecs[i].ill);
      lat_check();
      wait_empty();
    end

    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 5));
      rw  = 1'($urandom_range(0, 1));
      rd  = {$urandom, $urandom};
      rs  = 6'($urandom_range(0, 63));
      send(rop, rw, rd, rs, 5'(i + 1), model(rop, rw, rd, rs), (rop > 3'd4));
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_empty();
    chk("stream_count", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) chk("stream_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    pop_cyc.delete();
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_out_data", out_data, 64'h2);
        chk("stall_out_tag", 64'(out_tag), 64'd20);
      end
      drive(3'd0, 1'b0, 64'(idx + 1), 6'd1, 5'(20 + idx));
      #1;
      if (in_ready) begin
        push(64'(2 * (idx + 1)), 5'(20 + idx), 1'b0);
        idx++;
        acc++;
      end
    end
    chk("stall_accepts", 64'(acc), 64'd2);
    @(negedge clk);
    out_ready = 1'b1;
    drive(3'd0, 1'b0, 64'(idx + 1), 6'd1, 5'(20 + idx));
    #1;
    chk("full_accept_and_deliver", 64'(in_ready), 64'd1);
    if (in_ready) push(64'(2 * (idx + 1)), 5'(20 + idx), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_empty();
    chk("release_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) chk("release_no_bubble", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);

    out_ready = 1'b0;
    send(3'd0, 1'b0, 64'd1, 6'd2, 5'd1, 64'd4, 1'b0);
    send(3'd0, 1'b0, 64'd1, 6'd3, 5'd2, 64'd8, 1'b0);
    @(negedge clk);
    chk("full_before_flush", 64'(out_valid), 64'd1);
    flush = 1'b1;
    drive(3'd0, 1'b0, 64'd1, 6'd4, 5'd3);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("flush_s1_killed", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(3'd3, 1'b0, 64'd1, 6'd1, 5'd4, 64'd2, 1'b0);
    lat_check();
    wait_empty();

    out_ready = 1'b0;
    send(3'd0, 1'b0, 64'd5, 6'd4, 5'd7, 64'h50, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    chk("pre_reset_data", out_data, 64'h50);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_data", out_data, 64'd0);
    chk("async_reset_tag", 64'(out_tag), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("post_reset_no_result", 64'(out_valid), 64'd0);
    send(3'd7, 1'b0, 64'hFFFF, 6'd3, 5'd9, 64'd0, 1'b1);
    lat_check();
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
